// File: rtl/fifo_word_packer_pkg.sv
// Shared types and constants for the FIFO byte-to-word packer.
// Latency: n/a (types only). Backpressure: n/a.
// Lane geometry, packer state encoding and the partial-word keep helper.
package fifo_word_packer_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANES-1:0]  keep_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    // Keep mask covering the first n lanes (n = 0..4).
    function automatic keep_t keep_mask(input logic [2:0] n);
        return keep_t'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word valid/ready channel of the word packer.
// Latency: n/a (wiring only). Backpressure: out_ready stalls the word channel.
// master = packer side, slave = FIFO/downstream environment side.
interface fifo_word_packer_if;
    import fifo_word_packer_pkg::*;

    logic  fifo_rempty;
    logic  fifo_rinc;
    lane_t fifo_rdata;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    keep_t out_keep;

    modport master (
        input  fifo_rempty, fifo_rdata, out_ready,
        output fifo_rinc, out_valid, out_data, out_keep
    );

    modport slave (
        output fifo_rempty, fifo_rdata, out_ready,
        input  fifo_rinc, out_valid, out_data, out_keep
    );

endinterface

// File: rtl/fifo_word_packer_skid_byte_queue.sv
// Byte circular buffer with wrap-bit pointers; works for any DEPTH >= 1.
// Latency: push visible at head the cycle after; head is combinational from rptr.
// Backpressure: none internally; caller must not push when full or pop when empty.
module skid_byte_queue
    import fifo_word_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  lane_t         push_dat,
    input  logic          pop,
    output lane_t         pop_dat,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lane_t       mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        full;

    // Index wraps at DEPTH-1 and flips the top bit, so non-power-of-two depths work.
    function automatic logic [AW:0] ptr_next(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) begin
            return {~p[AW], {AW{1'b0}}};
        end
        return p + (AW+1)'(1);
    endfunction

    always_comb begin
        count = '0;
        if (wptr[AW] == rptr[AW]) begin
            count = CW'(wptr[AW-1:0]) - CW'(rptr[AW-1:0]);
        end else begin
            count = CW'(DEPTH) - CW'(rptr[AW-1:0]) + CW'(wptr[AW-1:0]);
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (count == CW'(DEPTH));
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= ptr_next(wptr);
            if (pop)  rptr <= ptr_next(rptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_dat;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from the async FIFO read side and packs four into a 32-bit word (first byte in [7:0]); optional PACK_FLUSH_EN flushes partial words.
// Latency: RD_LAT cycles FIFO->skid, then one byte packed per cycle; word valid the cycle after its 4th byte.
// Backpressure: out_ready low holds the word; the skid fills and pop credits stop fifo_rinc, so no byte is lost.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fifo_word_packer_if.master bus
);

    localparam int CW = $clog2(SKID_DEPTH + 1);

    if (RD_LAT < 1) begin : g_bad_lat
        $error("fifo_word_packer: RD_LAT must be at least 1");
    end
    if (SKID_DEPTH < RD_LAT + 1) begin : g_bad_depth
        $error("fifo_word_packer: SKID_DEPTH must be >= RD_LAT+1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fifo_word_packer: TIMEOUT must be at least 1");
    end

    logic [RD_LAT-1:0] pop_sr;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     skid_count;
    logic [CW:0]       credit_used;
    logic              arrive;
    logic              skid_empty;
    logic              skid_pop;
    lane_t             skid_head;
    logic              handshake;

    pack_state_t       state;
    logic [1:0]        lane_cnt;
    logic              out_valid_q;
    word_t             out_data_q;
    keep_t             out_keep_q;

    // Every issued pop holds a skid slot until its byte is packed, so the queue cannot overflow.
    assign inflight      = CW'($countones(pop_sr));
    assign credit_used   = {1'b0, skid_count} + {1'b0, inflight};
    assign bus.fifo_rinc = !rst && !bus.fifo_rempty && (credit_used < (CW+1)'(SKID_DEPTH));
    assign arrive        = pop_sr[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_sr <= '0;
        end else begin
            pop_sr <= (pop_sr << 1) | RD_LAT'(bus.fifo_rinc);
        end
    end

    skid_byte_queue #(
        .DEPTH (SKID_DEPTH),
        .CW    (CW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (arrive),
        .push_dat (bus.fifo_rdata),
        .pop      (skid_pop),
        .pop_dat  (skid_head),
        .count    (skid_count),
        .empty    (skid_empty)
    );

    assign handshake = (state == HOLD) && out_valid_q && bus.out_ready;
    assign skid_pop  = !skid_empty && ((state == FILL) || handshake);

`ifdef PACK_FLUSH_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            lane_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
`ifdef PACK_FLUSH_EN
            idle_cnt    <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (!skid_empty) begin
                        out_data_q[lane_cnt*LANE_W +: LANE_W] <= skid_head;
`ifdef PACK_FLUSH_EN
                        idle_cnt <= '0;
`endif
                        if (lane_cnt == 2'd3) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                            out_keep_q  <= '1;
                            lane_cnt    <= '0;
                        end else begin
                            lane_cnt <= lane_cnt + 2'd1;
                        end
                    end
`ifdef PACK_FLUSH_EN
                    else if (lane_cnt != 2'd0) begin
                        // Unwritten lanes are already zero, so the partial word goes out as-is.
                        if (idle_cnt == IW'(TIMEOUT - 1)) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                            out_keep_q  <= keep_mask({1'b0, lane_cnt});
                            lane_cnt    <= '0;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
`endif
                end
                HOLD: begin
                    if (handshake) begin
                        state       <= FILL;
                        out_valid_q <= 1'b0;
                        out_keep_q  <= '0;
                        if (!skid_empty) begin
                            out_data_q <= word_t'(skid_head);
                            lane_cnt   <= 2'd1;
                        end else begin
                            out_data_q <= '0;
                            lane_cnt   <= 2'd0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;

endmodule
